systolic_sweep_scheduler: RTL and testbench
===========================================

# systolic_sweep_scheduler

Sequences the systolic hold pattern shared by one row (or column) of tau units fed by the parallel block looper. Each block offset handed to a systolic group carries a group size. This block turns one accepted sweep command into a stream of beats. Each beat carries a ping-pong counter (0,1,…,g-1,g-1,…,1,0,0,1,…) and a one-hot hold mask that tells each tau whether it keeps the systolic datum on that beat. It replaces the fixed `counter == idx` rule with a handshaked scheduler the tau array consumes beat by beat.

## Interface
- N_TAU_X, 4, maximum systolic group size (taus per group)
- CNT_BW, 16, width of the beat count per sweep
- derived: CN = $clog2(N_TAU_X), CN1 = $clog2(N_TAU_X+1)

- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- src_rdy  in  1  sweep command valid
- src_ack  out  1  sweep command accepted
- i_gsize  in  CN1  active group size g, 0..N_TAU_X
- i_nbeat  in  CNT_BW  beats to emit for this sweep
- dst_rdy  out  1  beat valid
- dst_ack  in  1  beat consumed
- o_cnt  out  CN  ping-pong counter value of current beat
- o_dir  out  1  0 = ascending half, 1 = descending half
- o_hold  out  N_TAU_X  one-hot hold mask, bit i = (o_cnt == i), only for i < g
- o_last  out  1  current beat is the final beat of the sweep
- o_busy  out  1  sweep in progress (state RUN)

## Operation
- States:
  - IDLE: no sweep in progress.
  - RUN: beats are being emitted.
- IDLE:
  - src_ack = src_rdy (combinational).
  - On src_ack with g==0 or nbeat==0: stay IDLE and emit nothing (degenerate sweep).
  - Otherwise: latch g and nbeat, set cnt=0, dir=0, beat=0, and go to RUN.
- RUN:
  - dst_rdy = 1 and src_ack = 0.
  - Outputs hold while dst_ack is low.
  - On dst_ack, if beat==nbeat-1: go to IDLE.
  - On dst_ack otherwise: beat++ and advance the counter as below.
- Counter advance:
  - dir=0, cnt<g-1: cnt++.
  - dir=0, cnt==g-1: dir=1, cnt unchanged.
  - dir=1, cnt>0: cnt--.
  - dir=1, cnt==0: dir=0, cnt unchanged.
  - g==1 therefore yields 0,0,0,… with dir toggling every beat.
- o_hold:
  - Decoded from the registered cnt.
  - Bits at index >= latched g are forced to 0.
  - i_gsize > N_TAU_X is saturated to N_TAU_X at latch time.
- o_last = RUN && (beat == nbeat-1).
- Beat counter is CNT_BW wide and never wraps, since nbeat ≤ 2^CNT_BW-1.

## Timing
- Reset values:
  - state=IDLE.
  - dst_rdy=0, o_cnt=0, o_dir=0, o_hold=0, o_last=0, o_busy=0.
  - Latched g and nbeat = 0.
  - src_ack=0 (combinational from state).
- Latency:
  - Command acked in cycle T gives first beat dst_rdy=1 in T+1.
  - One beat per cycle when dst_ack is held high.
- A sweep of n beats occupies n cycles minimum. The next command can be acked in the cycle after the last dst_ack, so there is one idle gap cycle between sweeps.
- All outputs except src_ack are registered.
- dst_rdy never drops without dst_ack (rdy/ack rule), except on i_rst.
- Reset mid-sweep:
  - The next edge returns to IDLE with all outputs at reset values.
  - The in-flight beat is discarded.
- A src_rdy held during RUN is not acked until IDLE.

## Structure
- Shared package (TauCfg): N_TAU_X and the work-width constant CNT_BW.
- Sub-module PingPongCounter#(N):
  - Inputs: load, step, g.
  - Outputs: cnt, dir, with the advance rule above.
  - This sub-module is reused later by the i1 axis scheduler.
- Hold-mask decode uses the existing binary-to-one-hot helper.

## Test plan
- g=4, nbeat=16, dst_ack always 1:
  - o_cnt = 0,1,2,3,3,2,1,0,0,1,2,3,3,2,1,0.
  - o_hold for cnt==1 is 4'b0010.
  - o_last only on beat 16.
  - Back in IDLE on the next cycle.
- g=1, nbeat=5:
  - o_cnt all 0, o_dir = 0,1,0,1,0.
  - o_hold = 4'b0001 on every beat.
- g=3 with random dst_ack backpressure (50%):
  - Outputs stable while dst_ack=0.
  - Sequence 0,1,2,2,1,0,…
  - o_hold[3] never set.
- Degenerate commands:
  - g=0, nbeat=8 acked, and g=2, nbeat=0 acked.
  - Both: dst_rdy never rises, o_busy stays 0.
- Reset and queued command:
  - i_rst asserted at beat 5 of a g=4, nbeat=20 sweep: the next cycle has dst_rdy=0, o_cnt=0, o_busy=0.
  - A src_rdy held through reset is acked in the first IDLE cycle after reset deasserts.
  - Back-to-back commands: the second is acked exactly one cycle after the final dst_ack of the first.

Source files
------------

// File: rtl/systolic_sweep_scheduler_pkg.sv
// Shared configuration for the tau array schedulers.
//   N_TAU_X : maximum systolic group size (taus per group)
//   CNT_BW  : width of the per-sweep beat count
//   state_t : scheduler FSM states
//   cn_width: index width that stays at least one bit wide for tiny groups
package systolic_sweep_scheduler_pkg;

  localparam int N_TAU_X = 4;
  localparam int CNT_BW  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cn_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_sweep_scheduler_ping_pong_counter.sv
// Ping-pong counter: 0,1,..,g-1,g-1,..,1,0,0,1,.. with direction flag.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   load         : restart at cnt=0, dir=0 (wins over step)
//   step         : advance one position within group size g
//   g            : active group size (must be >= 1 while stepping)
//   cnt, dir     : registered counter value and half (0 asc, 1 desc)
//   cnt_nxt      : value cnt takes at the next edge (lets callers register
//                  decodes of it in step with cnt)
module ping_pong_counter
  import systolic_sweep_scheduler_pkg::*;
#(
  parameter int N   = N_TAU_X,
  localparam int CN  = cn_width(N),
  localparam int CN1 = $clog2(N + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           load,
  input  logic           step,
  input  logic [CN1-1:0] g,
  output logic [CN-1:0]  cnt,
  output logic           dir,
  output logic [CN-1:0]  cnt_nxt
);

  logic [CN-1:0] cnt_q;
  logic          dir_q;
  logic          dir_nxt;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_nxt = cnt_q;
    dir_nxt = dir_q;
    if (load) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (step) begin
      if (!dir_q) begin
        // At the top of the group the value repeats once while turning.
        if (CN1'(cnt_q) < g - CN1'(1)) cnt_nxt = cnt_q + CN'(1);
        else                           dir_nxt = 1'b1;
      end else begin
        if (cnt_q != '0) cnt_nxt = cnt_q - CN'(1);
        else             dir_nxt = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      dir_q <= dir_nxt;
    end
  end

  assign cnt = cnt_q;
  assign dir = dir_q;

endmodule

// File: rtl/systolic_sweep_scheduler.sv
// Systolic sweep scheduler: turns one accepted sweep command (group size g,
// beat count nbeat) into a handshaked stream of beats, each carrying the
// ping-pong counter, its direction and a one-hot hold mask for the taus.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   src_rdy / src_ack : sweep command handshake (ack combinational, IDLE only)
//   i_gsize, i_nbeat  : command group size (saturated to N_TAU_X) and beats
//   dst_rdy / dst_ack : beat handshake
//   o_cnt, o_dir      : ping-pong value and half of the current beat
//   o_hold            : bit i set when o_cnt == i and i < g
//   o_last            : current beat is the final beat of the sweep
//   o_busy            : sweep in progress
module systolic_sweep_scheduler
  import systolic_sweep_scheduler_pkg::*;
#(
  parameter int N_TAU_X = systolic_sweep_scheduler_pkg::N_TAU_X,
  parameter int CNT_BW  = systolic_sweep_scheduler_pkg::CNT_BW,
  localparam int CN  = cn_width(N_TAU_X),
  localparam int CN1 = $clog2(N_TAU_X + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               src_rdy,
  output logic               src_ack,
  input  logic [CN1-1:0]     i_gsize,
  input  logic [CNT_BW-1:0]  i_nbeat,
  output logic               dst_rdy,
  input  logic               dst_ack,
  output logic [CN-1:0]      o_cnt,
  output logic               o_dir,
  output logic [N_TAU_X-1:0] o_hold,
  output logic               o_last,
  output logic               o_busy
);

  state_t               state_q;
  logic [CN1-1:0]       g_q;
  logic [CNT_BW-1:0]    nbeat_q;
  logic [CNT_BW-1:0]    beat_q;
  logic                 last_q;
  logic [N_TAU_X-1:0]   hold_q;

  logic [CN1-1:0]       g_sat;
  logic                 cmd_go;
  logic                 step;
  logic [CN-1:0]        cnt_nxt;

  function automatic logic [N_TAU_X-1:0] hold_mask(input logic [CN-1:0]  c,
                                                    input logic [CN1-1:0] g);
    logic [N_TAU_X-1:0] m;
    for (int i = 0; i < N_TAU_X; i++) m[i] = (i < int'(g)) && (int'(c) == i);
    return m;
  endfunction

  // Ack is suppressed during reset so a command held through reset is taken
  // in the first clean IDLE cycle instead of being swallowed by the reset.
  assign src_ack = src_rdy && (state_q == IDLE) && !i_rst;
  assign g_sat   = (i_gsize > CN1'(N_TAU_X)) ? CN1'(N_TAU_X) : i_gsize;
  assign cmd_go  = src_ack && (g_sat != '0) && (i_nbeat != '0);
  assign step    = (state_q == RUN) && dst_ack && !last_q;

  ping_pong_counter #(.N(N_TAU_X)) u_ppc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (cmd_go),
    .step    (step),
    .g       (g_q),
    .cnt     (o_cnt),
    .dir     (o_dir),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      nbeat_q <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_go) begin
            state_q <= RUN;
            g_q     <= g_sat;
            nbeat_q <= i_nbeat;
            beat_q  <= '0;
            last_q  <= (i_nbeat == CNT_BW'(1));
            hold_q  <= hold_mask(cnt_nxt, g_sat);
          end
        end
        RUN: begin
          if (dst_ack) begin
            if (last_q) begin
              state_q <= IDLE;
              last_q  <= 1'b0;
              hold_q  <= '0;
            end else begin
              beat_q <= beat_q + CNT_BW'(1);
              // Registered look-ahead: the new beat is last when it is nbeat-1.
              last_q <= (beat_q + CNT_BW'(1)) == (nbeat_q - CNT_BW'(1));
              hold_q <= hold_mask(cnt_nxt, g_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dst_rdy = (state_q == RUN);
  assign o_busy  = (state_q == RUN);
  assign o_last  = last_q;
  assign o_hold  = hold_q;

endmodule

// File: tb/tb_systolic_sweep_scheduler.sv
// Self-checking bench for systolic_sweep_scheduler: a reference model pushes
// expected beats into a scoreboard when a command is accepted; beats are
// popped and compared as the DUT hands them over.
module tb_systolic_sweep_scheduler;

  localparam int NT  = 4;
  localparam int CBW = 16;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           src_rdy;
  logic           src_ack;
  logic [2:0]     i_gsize;
  logic [CBW-1:0] i_nbeat;
  logic           dst_rdy;
  logic           dst_ack;
  logic [1:0]     o_cnt;
  logic           o_dir;
  logic [NT-1:0]  o_hold;
  logic           o_last;
  logic           o_busy;

  typedef struct {
    int cnt;
    bit dir;
    int hold;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;

  systolic_sweep_scheduler dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .src_rdy (src_rdy),
    .src_ack (src_ack),
    .i_gsize (i_gsize),
    .i_nbeat (i_nbeat),
    .dst_rdy (dst_rdy),
    .dst_ack (dst_ack),
    .o_cnt   (o_cnt),
    .o_dir   (o_dir),
    .o_hold  (o_hold),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sweep: g saturates at NT; degenerate commands yield no beats.
  task automatic push_sweep(input int g, input int n);
    int gs, c;
    bit d;
    beat_t b;
    gs = (g > NT) ? NT : g;
    if (gs == 0 || n == 0) return;
    c = 0;
    d = 1'b0;
    for (int k = 0; k < n; k++) begin
      b.cnt  = c;
      b.dir  = d;
      b.hold = 1 << c;
      b.last = (k == n - 1);
      sb.push_back(b);
      if (!d) begin
        if (c < gs - 1) c++;
        else            d = 1'b1;
      end else begin
        if (c > 0) c--;
        else       d = 1'b0;
      end
    end
  endtask

  task automatic send_cmd(input int g, input int n);
    int w;
    @(negedge i_clk);
    src_rdy = 1'b1;
    i_gsize = 3'(g);
    i_nbeat = CBW'(n);
    #1;
    w = 0;
    while (!src_ack && w < 50) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    chk("cmd_ack", src_ack, 1);
    push_sweep(g, n);
    @(posedge i_clk);
    #1 src_rdy = 1'b0;
  endtask

  // Consume beats with pct% acceptance. stop_after >= 0 returns at the
  // negedge where that many beats have been consumed (dst_ack low).
  task automatic drain(input int pct, input int stop_after, input bit no_ack_chk);
    int    consumed = 0;
    int    budget   = 0;
    bit    stalled  = 1'b0;
    bit    ack;
    beat_t e;
    logic [1:0]    s_cnt;
    logic          s_dir;
    logic [NT-1:0] s_hold;
    logic          s_last;
    while (sb.size() > 0) begin
      @(negedge i_clk);
      if (stop_after >= 0 && consumed == stop_after) begin
        dst_ack = 1'b0;
        return;
      end
      budget++;
      if (budget > 2000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: observed=%0d beats pending expected=0", sb.size());
        sb.delete();
        break;
      end
      if (dst_rdy) begin
        chk("busy_eq_rdy", o_busy, 1);
        if (no_ack_chk) chk("no_ack_in_run", src_ack, 0);
        if (stalled) begin
          chk("stall_cnt", o_cnt, s_cnt);
          chk("stall_dir", o_dir, s_dir);
          chk("stall_hold", o_hold, s_hold);
          chk("stall_last", o_last, s_last);
        end
        ack = ($urandom_range(99) < pct);
        if (ack) begin
          e = sb.pop_front();
          chk("beat_cnt", o_cnt, e.cnt);
          chk("beat_dir", o_dir, e.dir);
          chk("beat_hold", o_hold, e.hold);
          chk("beat_last", o_last, e.last);
          consumed++;
        end
        stalled = !ack;
        s_cnt   = o_cnt;
        s_dir   = o_dir;
        s_hold  = o_hold;
        s_last  = o_last;
        dst_ack = ack;
      end else begin
        dst_ack = 1'b0;
        stalled = 1'b0;
      end
    end
    @(negedge i_clk);
    dst_ack = 1'b0;
    chk("idle_after_rdy", dst_rdy, 0);
    chk("idle_after_busy", o_busy, 0);
  endtask

  initial begin
    i_rst   = 1'b1;
    src_rdy = 1'b0;
    i_gsize = '0;
    i_nbeat = '0;
    dst_ack = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_dst_rdy", dst_rdy, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_dir", o_dir, 0);
    chk("rst_hold", o_hold, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_src_ack", src_ack, 0);
    i_rst = 1'b0;

    // Full-size group, continuous consumption.
    send_cmd(4, 16);
    drain(100, -1, 1'b0);

    // Single-tau group: value pinned at 0, direction toggles.
    send_cmd(1, 5);
    drain(100, -1, 1'b0);

    // g=3 under random backpressure.
    send_cmd(3, 14);
    drain(50, -1, 1'b0);

    // Oversized group saturates to NT.
    send_cmd(7, 6);
    drain(100, -1, 1'b0);

    // Single-beat sweep: first beat is also last.
    send_cmd(2, 1);
    drain(100, -1, 1'b0);

    // Degenerate commands: acked, never produce beats.
    send_cmd(0, 8);
    repeat (4) begin
      @(negedge i_clk);
      chk("degen_g0_rdy", dst_rdy, 0);
      chk("degen_g0_busy", o_busy, 0);
    end
    send_cmd(2, 0);
    repeat (4) begin
      @(negedge i_clk);
      chk("degen_n0_rdy", dst_rdy, 0);
      chk("degen_n0_busy", o_busy, 0);
    end

    // Reset at beat 5 of a long sweep, with a command held through reset.
    send_cmd(4, 20);
    drain(100, 5, 1'b0);
    chk("pre_rst_cnt", o_cnt, sb[0].cnt);
    i_rst   = 1'b1;
    src_rdy = 1'b1;
    i_gsize = 3'd2;
    i_nbeat = CBW'(3);
    #1;
    chk("rst_gates_ack", src_ack, 0);
    @(negedge i_clk);
    chk("midrst_dst_rdy", dst_rdy, 0);
    chk("midrst_cnt", o_cnt, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_hold", o_hold, 0);
    chk("midrst_last", o_last, 0);
    sb.delete();
    i_rst = 1'b0;
    #1;
    chk("held_cmd_ack", src_ack, 1);
    push_sweep(2, 3);
    @(posedge i_clk);
    #1 src_rdy = 1'b0;
    drain(100, -1, 1'b0);

    // Back-to-back: second command held during the first sweep.
    send_cmd(2, 4);
    src_rdy = 1'b1;
    i_gsize = 3'd3;
    i_nbeat = CBW'(4);
    drain(100, -1, 1'b1);
    chk("b2b_ack_after_last", src_ack, 1);
    push_sweep(3, 4);
    @(posedge i_clk);
    #1 src_rdy = 1'b0;
    @(negedge i_clk);
    chk("b2b_first_beat_rdy", dst_rdy, 1);
    drain(100, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
